// File: rtl/reram_xbar_pkg.sv
// Shared encodings for the ReRAM crossbar controller: ops, FSM states, register map.
package reram_xbar_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_SET   = 2'b01,
      OP_RESET = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_SAMPLE,
      ST_RELAX
   } state_e;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_ADDR   = 4'h4;
   localparam logic [3:0] OFF_TIMING = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   // Byte-lane merge of a Wishbone write into an existing 32-bit image.
   function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
      logic [31:0] m;
      m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      return (old_v & ~m) | (new_v & m);
   endfunction

endpackage

// File: rtl/reram_xbar_ctrl_regs.sv
// Wishbone slave decode and register file for the crossbar controller.
module reram_xbar_regs
   import reram_xbar_pkg::*;
#(
   parameter int unsigned PW_W     = 8,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            we_i,
   input  logic [3:0]      sel_i,
   input  logic [31:0]     adr_i,
   input  logic [31:0]     dat_i,
   output logic            ack_o,
   output logic [31:0]     dat_o,
   input  logic            busy_i,
   input  logic            done_i,
   input  logic            result_i,
   input  logic            error_i,
   output logic            ctrl_wr_c,
   output logic            ctrl_start_c,
   output logic [1:0]      ctrl_op_c,
   output logic [4:0]      row_o,
   output logic [4:0]      col_o,
   output logic [PW_W-1:0] setup_o,
   output logic [PW_W-1:0] pulse_o
);

   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;
   logic [1:0]      op_q, op_d;
   logic [4:0]      row_q, row_d, col_q, col_d;
   logic [PW_W-1:0] setup_q, setup_d, pulse_q, pulse_d;
   logic            hit_c, req_c;
   logic [3:0]      off_c;
   logic [31:0]     addr_img_c, tim_img_c, addr_wr_c, tim_wr_c;
   logic            unused_c;

   assign hit_c        = (adr_i[31:4] == BASE_ADR[31:4]) && (adr_i[1:0] == 2'b00);
   assign off_c        = adr_i[3:0];
   // Guard on ack_q forces one idle ack cycle between back-to-back requests.
   assign req_c        = cyc_i & stb_i & hit_c & ~ack_q;
   assign ctrl_wr_c    = req_c & we_i & (off_c == OFF_CTRL);
   assign ctrl_start_c = dat_i[0];
   assign ctrl_op_c    = dat_i[2:1];

   assign addr_img_c = (32'(col_q) << 8) | 32'(row_q);
   assign tim_img_c  = (32'(pulse_q) << 16) | 32'(setup_q);
   assign addr_wr_c  = sel_merge(addr_img_c, dat_i, sel_i);
   assign tim_wr_c   = sel_merge(tim_img_c, dat_i, sel_i);
   assign unused_c   = ^{dat_i, sel_i, addr_wr_c, tim_wr_c};

   // Register writes, read mux and single-cycle ack.
   always_comb begin
      ack_d   = req_c;
      dat_d   = '0;
      op_d    = op_q;
      row_d   = row_q;
      col_d   = col_q;
      setup_d = setup_q;
      pulse_d = pulse_q;
      if (req_c && we_i) begin
         case (off_c)
            OFF_CTRL:   op_d = dat_i[2:1];
            OFF_ADDR: begin
               row_d = addr_wr_c[4:0];
               col_d = addr_wr_c[12:8];
            end
            OFF_TIMING: begin
               setup_d = tim_wr_c[PW_W-1:0];
               pulse_d = tim_wr_c[16 +: PW_W];
            end
            default: ;
         endcase
      end else if (req_c) begin
         case (off_c)
            OFF_CTRL:   dat_d = {29'b0, op_q, 1'b0};
            OFF_ADDR:   dat_d = addr_img_c;
            OFF_TIMING: dat_d = tim_img_c;
            OFF_STATUS: dat_d = {28'b0, error_i, result_i, done_i, busy_i};
            default:    dat_d = '0;
         endcase
      end
   end

   // Register state with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q   <= 1'b0;
         dat_q   <= '0;
         op_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
         setup_q <= '0;
         pulse_q <= '0;
      end else begin
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         op_q    <= op_d;
         row_q   <= row_d;
         col_q   <= col_d;
         setup_q <= setup_d;
         pulse_q <= pulse_d;
      end
   end

   assign ack_o   = ack_q;
   assign dat_o   = dat_q;
   assign row_o   = row_q;
   assign col_o   = col_q;
   assign setup_o = setup_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/reram_xbar_ctrl.sv
// ReRAM crossbar controller: sequences setup/pulse/sample for one cell per command.
module reram_xbar_ctrl
   import reram_xbar_pkg::*;
#(
   parameter int unsigned ROWS     = 8,
   parameter int unsigned COLS     = 8,
   parameter int unsigned PW_W     = 8,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic [ROWS-1:0] row_en,
   output logic [COLS-1:0] col_en,
   output logic            mode_read,
   output logic            mode_set,
   output logic            mode_reset,
   input  logic            sense_i,
   output logic            busy_o,
   output logic            irq_o
);

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [PW_W-1:0] cnt_q, cnt_d, pulse_q, pulse_d;
   logic [4:0]      row_q, row_d, col_q, col_d;
   logic            done_q, done_d, error_q, error_d, result_q, result_d;
   logic            sync1_q, sync2_q;
   logic [ROWS-1:0] row_en_q, row_en_d;
   logic [COLS-1:0] col_en_q, col_en_d;
   logic            rd_q, rd_d, set_q, set_d, rst_q, rst_d, busy_q, busy_d, irq_q, irq_d;
   logic            sel_on_c, valid_c;

   logic            ctrl_wr_c, ctrl_start_c;
   logic [1:0]      ctrl_op_c;
   logic [4:0]      reg_row, reg_col;
   logic [PW_W-1:0] reg_setup, reg_pulse;

   reram_xbar_regs #(.PW_W(PW_W), .BASE_ADR(BASE_ADR)) u_regs (
      .clk_i        (wb_clk_i),
      .rst_i        (wb_rst_i),
      .cyc_i        (wbs_cyc_i),
      .stb_i        (wbs_stb_i),
      .we_i         (wbs_we_i),
      .sel_i        (wbs_sel_i),
      .adr_i        (wbs_adr_i),
      .dat_i        (wbs_dat_i),
      .ack_o        (wbs_ack_o),
      .dat_o        (wbs_dat_o),
      .busy_i       (busy_q),
      .done_i       (done_q),
      .result_i     (result_q),
      .error_i      (error_q),
      .ctrl_wr_c    (ctrl_wr_c),
      .ctrl_start_c (ctrl_start_c),
      .ctrl_op_c    (ctrl_op_c),
      .row_o        (reg_row),
      .col_o        (reg_col),
      .setup_o      (reg_setup),
      .pulse_o      (reg_pulse)
   );

   // A zero timing field still yields one cycle: load max(x,1)-1.
   function automatic logic [PW_W-1:0] ld_cnt(input logic [PW_W-1:0] x);
      return (x == '0) ? '0 : x - PW_W'(1);
   endfunction

   assign valid_c = (op_e'(ctrl_op_c) != OP_RSVD) && (32'(reg_row) < ROWS) &&
                    (32'(reg_col) < COLS);

   // Next-state, status flags and next values of the registered drive outputs.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      pulse_d  = pulse_q;
      row_d    = row_q;
      col_d    = col_q;
      done_d   = done_q;
      error_d  = error_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_wr_c && ctrl_start_c) begin
               if (valid_c) begin
                  done_d  = 1'b0;
                  error_d = 1'b0;
                  op_d    = op_e'(ctrl_op_c);
                  row_d   = reg_row;
                  col_d   = reg_col;
                  pulse_d = reg_pulse;
                  cnt_d   = ld_cnt(reg_setup);
                  state_d = ST_SETUP;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = ld_cnt(pulse_q);
               state_d = ST_PULSE;
            end else begin
               cnt_d = cnt_q - PW_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = (op_q == OP_READ) ? ST_SAMPLE : ST_RELAX;
            end else begin
               cnt_d = cnt_q - PW_W'(1);
            end
         end
         ST_SAMPLE: begin
            result_d = sync2_q;
            state_d  = ST_RELAX;
         end
         ST_RELAX: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && ctrl_wr_c) begin
         error_d = 1'b1;
      end

      sel_on_c = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_SAMPLE);
      row_en_d = sel_on_c ? (ROWS'(1) << row_d) : '0;
      col_en_d = sel_on_c ? (COLS'(1) << col_d) : '0;
      rd_d     = ((state_d == ST_PULSE) && (op_d == OP_READ)) || (state_d == ST_SAMPLE);
      set_d    = (state_d == ST_PULSE) && (op_d == OP_SET);
      rst_d    = (state_d == ST_PULSE) && (op_d == OP_RESET);
      busy_d   = (state_d != ST_IDLE);
      irq_d    = (state_d == ST_RELAX);
   end

   // State, latched operation, status flags, sense synchroniser and output registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_READ;
         cnt_q    <= '0;
         pulse_q  <= '0;
         row_q    <= '0;
         col_q    <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         result_q <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         row_en_q <= '0;
         col_en_q <= '0;
         rd_q     <= 1'b0;
         set_q    <= 1'b0;
         rst_q    <= 1'b0;
         busy_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         pulse_q  <= pulse_d;
         row_q    <= row_d;
         col_q    <= col_d;
         done_q   <= done_d;
         error_q  <= error_d;
         result_q <= result_d;
         sync1_q  <= sense_i;
         sync2_q  <= sync1_q;
         row_en_q <= row_en_d;
         col_en_q <= col_en_d;
         rd_q     <= rd_d;
         set_q    <= set_d;
         rst_q    <= rst_d;
         busy_q   <= busy_d;
         irq_q    <= irq_d;
      end
   end

   assign row_en     = row_en_q;
   assign col_en     = col_en_q;
   assign mode_read  = rd_q;
   assign mode_set   = set_q;
   assign mode_reset = rst_q;
   assign busy_o     = busy_q;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_reram_xbar_ctrl.sv
// Self-checking bench for reram_xbar_ctrl: register table plus operation sequences.
module tb_reram_xbar_ctrl;
   import reram_xbar_pkg::*;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk, rst;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat;
   logic [7:0]  row_en, col_en;
   logic        mode_read, mode_set, mode_reset, sense, busy, irq;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      logic        we;
      logic [3:0]  off;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[16];

   reram_xbar_ctrl #(.ROWS(8), .COLS(8), .PW_W(8), .BASE_ADR(BASE)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_cyc_i  (cyc),
      .wbs_stb_i  (stb),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (wdat),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (rdat),
      .row_en     (row_en),
      .col_en     (col_en),
      .mode_read  (mode_read),
      .mode_set   (mode_set),
      .mode_reset (mode_reset),
      .sense_i    (sense),
      .busy_o     (busy),
      .irq_o      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One Wishbone access; waits a bounded number of cycles for ack.
   task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic ok);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      ok = 1'b0; rd = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            ok = 1'b1;
            rd = rdat;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      logic        ok;
      wb_cycle(1'b1, BASE + 32'(off), d, s, rd, ok);
      chk("wr_ack", 32'(ok), 32'h1);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
      logic [31:0] rd, e;
      logic        ok;
      sb_q.push_back(exp);
      wb_cycle(1'b0, BASE + 32'(off), 32'h0, 4'hF, rd, ok);
      e = sb_q.pop_front();
      if (!ok) chk({name, "_ack"}, 32'h0, 32'h1);
      else     chk(name, rd, e);
   endtask

   // Watches the crossbar drive lines cycle by cycle until the operation finishes.
   task automatic observe(input logic [7:0] er, input logic [7:0] ec, input int maxc,
                          output int ns, output int nr, output int nse, output int nre,
                          output int ni, output int nb, output int bad);
      int strobes;
      ns = 0; nr = 0; nse = 0; nre = 0; ni = 0; nb = 0; bad = 0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         strobes = int'(mode_read) + int'(mode_set) + int'(mode_reset);
         if (busy) nb++;
         if (strobes > 1) bad++;
         if (strobes > 0 && (row_en == 8'h0 || col_en == 8'h0)) bad++;
         if ((row_en != 8'h0 || col_en != 8'h0) && (row_en != er || col_en != ec)) bad++;
         if (row_en != 8'h0 && col_en != 8'h0 && strobes == 0) ns++;
         if (mode_read) nr++;
         if (mode_set) nse++;
         if (mode_reset) nre++;
         if (irq) ni++;
         if (ni > 0 && !busy) break;
      end
   endtask

   task automatic chk_counts(input string name, input int ns, input int nr, input int nse,
                             input int nre, input int ni, input int bad,
                             input int ens, input int enr, input int ense, input int enre,
                             input int eni);
      chk({name, "_setup"}, 32'(ns), 32'(ens));
      chk({name, "_read"}, 32'(nr), 32'(enr));
      chk({name, "_set"}, 32'(nse), 32'(ense));
      chk({name, "_reset"}, 32'(nre), 32'(enre));
      chk({name, "_irq"}, 32'(ni), 32'(eni));
      chk({name, "_drive"}, 32'(bad), 32'h0);
   endtask

   initial begin
      int          ns, nr, nse, nre, ni, nb, bad;
      logic [31:0] rd;
      logic        ok;

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      adr = '0; wdat = '0; sense = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outs", {row_en, col_en, mode_read, mode_set, mode_reset, busy, irq, ack}, 32'h0);
      chk("reset_dat", rdat, 32'h0);
      rst = 1'b0;

      tbl[0]  = '{1'b0, OFF_STATUS, 32'h0,         4'h0, 32'h0000_0000};
      tbl[1]  = '{1'b0, OFF_ADDR,   32'h0,         4'h0, 32'h0000_0000};
      tbl[2]  = '{1'b0, OFF_TIMING, 32'h0,         4'h0, 32'h0000_0000};
      tbl[3]  = '{1'b0, OFF_CTRL,   32'h0,         4'h0, 32'h0000_0000};
      tbl[4]  = '{1'b1, OFF_ADDR,   32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[5]  = '{1'b0, OFF_ADDR,   32'h0,         4'h0, 32'h0000_1F1F};
      tbl[6]  = '{1'b1, OFF_ADDR,   32'h0000_0000, 4'h1, 32'h0};
      tbl[7]  = '{1'b0, OFF_ADDR,   32'h0,         4'h0, 32'h0000_1F00};
      tbl[8]  = '{1'b1, OFF_TIMING, 32'hFFFF_FFFF, 4'h4, 32'h0};
      tbl[9]  = '{1'b0, OFF_TIMING, 32'h0,         4'h0, 32'h00FF_0000};
      tbl[10] = '{1'b1, OFF_TIMING, 32'h0000_0012, 4'h1, 32'h0};
      tbl[11] = '{1'b0, OFF_TIMING, 32'h0,         4'h0, 32'h00FF_0012};
      tbl[12] = '{1'b1, OFF_TIMING, 32'h0000_0000, 4'hF, 32'h0};
      tbl[13] = '{1'b0, OFF_TIMING, 32'h0,         4'h0, 32'h0000_0000};
      tbl[14] = '{1'b1, OFF_CTRL,   32'h0000_0002, 4'hF, 32'h0};
      tbl[15] = '{1'b0, OFF_CTRL,   32'h0,         4'h0, 32'h0000_0002};

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].we) wr(tbl[i].off, tbl[i].dat, tbl[i].sel);
         else           rd_chk($sformatf("tbl%0d", i), tbl[i].off, tbl[i].exp);
      end
      rd_chk("status_after_nostart", OFF_STATUS, 32'h0);

      // Unmapped addresses never ack.
      wb_cycle(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, ok);
      chk("unmapped_ack", 32'(ok), 32'h0);
      wb_cycle(1'b0, 32'h3100_0000, 32'h0, 4'hF, rd, ok);
      chk("other_base_ack", 32'(ok), 32'h0);

      // Set at row 2, col 5 with setup=3, pulse=5.
      wr(OFF_TIMING, 32'h0005_0003, 4'hF);
      wr(OFF_ADDR, 32'h0000_0502, 4'hF);
      wr(OFF_CTRL, 32'h0000_0003, 4'hF);
      observe(8'h04, 8'h20, 100, ns, nr, nse, nre, ni, nb, bad);
      chk_counts("set", ns, nr, nse, nre, ni, bad, 3, 0, 5, 0, 1);
      rd_chk("set_status", OFF_STATUS, 32'h2);

      // Read with sense high, setup=1, pulse=2.
      sense = 1'b1;
      wr(OFF_TIMING, 32'h0002_0001, 4'hF);
      wr(OFF_ADDR, 32'h0000_0701, 4'hF);
      wr(OFF_CTRL, 32'h0000_0001, 4'hF);
      observe(8'h02, 8'h80, 100, ns, nr, nse, nre, ni, nb, bad);
      chk_counts("read", ns, nr, nse, nre, ni, bad, 1, 3, 0, 0, 1);
      rd_chk("read_status", OFF_STATUS, 32'h6);

      // Out-of-range row is rejected without any drive activity.
      wr(OFF_ADDR, 32'h0000_0008, 4'hF);
      wr(OFF_CTRL, 32'h0000_0001, 4'hF);
      observe(8'h00, 8'h00, 20, ns, nr, nse, nre, ni, nb, bad);
      chk_counts("badrow", ns, nr, nse, nre, ni, bad, 0, 0, 0, 0, 0);
      chk("badrow_busy", 32'(nb), 32'h0);
      rd_chk("badrow_status", OFF_STATUS, 32'hE);

      // Zero timing gives single-cycle phases; reset op leaves result intact.
      wr(OFF_TIMING, 32'h0000_0000, 4'hF);
      wr(OFF_ADDR, 32'h0000_0000, 4'hF);
      wr(OFF_CTRL, 32'h0000_0005, 4'hF);
      observe(8'h01, 8'h01, 100, ns, nr, nse, nre, ni, nb, bad);
      chk_counts("pulse0", ns, nr, nse, nre, ni, bad, 1, 0, 0, 1, 1);
      rd_chk("pulse0_status", OFF_STATUS, 32'h6);

      // Reserved op is rejected.
      wr(OFF_CTRL, 32'h0000_0007, 4'hF);
      observe(8'h00, 8'h00, 20, ns, nr, nse, nre, ni, nb, bad);
      chk_counts("rsvd", ns, nr, nse, nre, ni, bad, 0, 0, 0, 0, 0);
      chk("rsvd_busy", 32'(nb), 32'h0);
      rd_chk("rsvd_status", OFF_STATUS, 32'hE);

      // CTRL and ADDR writes during PULSE must not disturb the running set.
      wr(OFF_TIMING, 32'h0006_0002, 4'hF);
      wr(OFF_ADDR, 32'h0000_0103, 4'hF);
      wr(OFF_CTRL, 32'h0000_0003, 4'hF);
      fork
         observe(8'h08, 8'h02, 100, ns, nr, nse, nre, ni, nb, bad);
         begin
            repeat (3) @(negedge clk);
            wr(OFF_CTRL, 32'h0000_0003, 4'hF);
            wr(OFF_ADDR, 32'h0000_0707, 4'hF);
         end
      join
      chk_counts("busywr", ns, nr, nse, nre, ni, bad, 2, 0, 6, 0, 1);
      rd_chk("busywr_status", OFF_STATUS, 32'hE);
      rd_chk("busywr_addr", OFF_ADDR, 32'h0000_0707);

      // Reset mid-PULSE clears every output at once and aborts without done.
      wr(OFF_TIMING, 32'h000A_0001, 4'hF);
      wr(OFF_ADDR, 32'h0000_0101, 4'hF);
      wr(OFF_CTRL, 32'h0000_0003, 4'hF);
      repeat (4) @(negedge clk);
      chk("rst_pre_set", 32'(mode_set), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_outs", {row_en, col_en, mode_read, mode_set, mode_reset, busy, irq, ack}, 32'h0);
      chk("rst_dat", rdat, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("rst_status", OFF_STATUS, 32'h0);
      rd_chk("rst_timing", OFF_TIMING, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
